// File: rtl/xgmii_frame_checker.sv
// -----------------------------------------------------------------------------
// xgmii_frame_checker
//
// Watches the 64-bit XGMII receive stream from eth_phy_10g and classifies
// every frame as good or bad. A frame starts with /S/ on lane 0 and ends with
// /T/. The checker flags frames that are too short or too long, that carry
// /E/ or any unexpected control character, or that have non-/I/ lanes after
// /T/. Each frame produces exactly one pulse, and saturating counters record
// how many good and bad frames were seen.
//
// Optional feature macro:
//   XGMII_CHK_PREAMBLE_EN - when defined, the /S/ word must be exactly
//                           FB,55,55,55,55,55,55,D5 with rxc=8'h01. Any other
//                           value marks the frame bad when it ends.
//
// Parameters:
//   MIN_LEN    - minimum legal frame length in bytes (preamble/SFD included)
//   MAX_LEN    - maximum legal frame length in bytes
//   CNT_WIDTH  - width of good_count / bad_count
//
// Ports:
//   rx_clk      in   1          sole clock, rising edge
//   rx_rst      in   1          synchronous active-low reset (0 = reset)
//   xgmii_rxd   in   64         lane k = bits [8k+7:8k], lane 0 first on wire
//   xgmii_rxc   in   8          bit k = 1 marks lane k as a control character
//   cnt_clr     in   1          synchronous clear of both counters
//   frame_good  out  1          one-cycle pulse, legal frame ended
//   frame_bad   out  1          one-cycle pulse, illegal frame ended/aborted
//   frame_len   out  16         byte length of the last ended frame
//   good_count  out  CNT_WIDTH  saturating good-frame counter
//   bad_count   out  CNT_WIDTH  saturating bad-frame counter
//   in_frame    out  1          1 while in FRAME or DROP
// -----------------------------------------------------------------------------
module xgmii_frame_checker #(
    parameter int MIN_LEN   = 72,
    parameter int MAX_LEN   = 1526,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 rx_clk,
    input  logic                 rx_rst,
    input  logic [63:0]          xgmii_rxd,
    input  logic [7:0]           xgmii_rxc,
    input  logic                 cnt_clr,
    output logic                 frame_good,
    output logic                 frame_bad,
    output logic [15:0]          frame_len,
    output logic [CNT_WIDTH-1:0] good_count,
    output logic [CNT_WIDTH-1:0] bad_count,
    output logic                 in_frame
);

    localparam logic [7:0]  CH_IDLE  = 8'h07;
    localparam logic [7:0]  CH_START = 8'hFB;
    localparam logic [7:0]  CH_TERM  = 8'hFD;
    localparam logic [7:0]  CH_ERROR = 8'hFE;
    localparam logic [63:0] IDLE_WORD = 64'h0707070707070707;

    localparam logic [15:0] MIN_L    = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L    = 16'(MAX_LEN);
    localparam logic [15:0] START_LEN = 16'd7;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [15:0] length, length_n;
    logic        err, err_n;

    // End-of-frame decision for the current word; registered into the pulses.
    logic        end_frame;
    logic        end_bad;
    logic [15:0] end_len;

    // Per-word lane decode.
    logic        t_found;
    logic [2:0]  t_lane;
    logic [3:0]  data_cnt;
    logic        word_err;
    logic        e_found;
    logic        s_lane0;
    logic        all_idle;
    logic        pre_bad;
    logic [16:0] len_sum;
    logic [15:0] len_add;

    assign s_lane0  = xgmii_rxc[0] && (xgmii_rxd[7:0] == CH_START);
    assign all_idle = (xgmii_rxc == 8'hFF) && (xgmii_rxd == IDLE_WORD);

`ifdef XGMII_CHK_PREAMBLE_EN
    assign pre_bad = !((xgmii_rxd == 64'hD5555555555555FB) && (xgmii_rxc == 8'h01));
`else
    assign pre_bad = 1'b0;
`endif

    // Lane scan: locate the first /T/, count data lanes ahead of it, and flag
    // any control character before /T/ or any non-/I/ lane after it.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        t_found  = 1'b0;
        t_lane   = 3'd0;
        data_cnt = 4'd0;
        word_err = 1'b0;
        e_found  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!t_found && xgmii_rxc[k] && (xgmii_rxd[8*k +: 8] == CH_TERM)) begin
                t_found = 1'b1;
                t_lane  = 3'(k);
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (!t_found || (k < int'(t_lane))) begin
                if (!xgmii_rxc[k]) begin
                    data_cnt = data_cnt + 4'd1;
                end else begin
                    word_err = 1'b1;
                    if (xgmii_rxd[8*k +: 8] == CH_ERROR) e_found = 1'b1;
                end
            end else if (k > int'(t_lane)) begin
                if (!(xgmii_rxc[k] && (xgmii_rxd[8*k +: 8] == CH_IDLE))) begin
                    word_err = 1'b1;
                    if (xgmii_rxc[k] && (xgmii_rxd[8*k +: 8] == CH_ERROR)) e_found = 1'b1;
                end
            end
        end
    end

    // /T/ on lane k contributes its k leading bytes; otherwise every data
    // lane contributes one byte. The running length saturates at 16'hFFFF.
    always_comb begin
        if (t_found) len_sum = {1'b0, length} + {14'd0, t_lane};
        else         len_sum = {1'b0, length} + {13'd0, data_cnt};
        len_add = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    end

    // Next-state and end-of-frame decode.
    always_comb begin
        state_n   = state;
        length_n  = length;
        err_n     = err;
        end_frame = 1'b0;
        end_bad   = 1'b0;
        end_len   = length;
        case (state)
            ST_IDLE: begin
                if (s_lane0) begin
                    state_n  = ST_FRAME;
                    length_n = START_LEN;
                    err_n    = pre_bad;
                end
            end
            ST_FRAME: begin
                if (s_lane0) begin
                    // New /S/ aborts the open frame; its lanes 1-7 open the next one.
                    end_frame = 1'b1;
                    end_bad   = 1'b1;
                    end_len   = length;
                    length_n  = START_LEN;
                    err_n     = pre_bad;
                end else if (t_found) begin
                    end_frame = 1'b1;
                    end_len   = len_add;
                    end_bad   = err || word_err || (len_add < MIN_L) || (len_add > MAX_L);
                    state_n   = ST_IDLE;
                    length_n  = 16'd0;
                    err_n     = 1'b0;
                end else if (e_found) begin
                    state_n  = ST_DROP;
                    length_n = len_add;
                    err_n    = 1'b1;
                end else begin
                    length_n = len_add;
                    err_n    = err || word_err;
                end
            end
            ST_DROP: begin
                if (s_lane0) begin
                    end_frame = 1'b1;
                    end_bad   = 1'b1;
                    end_len   = length;
                    state_n   = ST_FRAME;
                    length_n  = START_LEN;
                    err_n     = pre_bad;
                end else if (t_found || all_idle) begin
                    end_frame = 1'b1;
                    end_bad   = 1'b1;
                    end_len   = len_add;
                    state_n   = ST_IDLE;
                    length_n  = 16'd0;
                    err_n     = 1'b0;
                end else begin
                    length_n = len_add;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                length_n = 16'd0;
                err_n    = 1'b0;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge rx_clk) begin
        if (!rx_rst) begin
            state      <= ST_IDLE;
            length     <= 16'd0;
            err        <= 1'b0;
            frame_good <= 1'b0;
            frame_bad  <= 1'b0;
            frame_len  <= 16'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state      <= state_n;
            length     <= length_n;
            err        <= err_n;
            frame_good <= end_frame && !end_bad;
            frame_bad  <= end_frame && end_bad;
            if (end_frame) frame_len <= end_len;
        end
    end

    // Counters follow the registered pulses; a clear coinciding with a pulse
    // leaves that pulse counted.
    always_ff @(posedge rx_clk) begin
        if (!rx_rst) begin
            good_count <= '0;
            bad_count  <= '0;
        end else begin
            if (cnt_clr)
                good_count <= frame_good ? CNT_ONE : '0;
            else if (frame_good && (good_count != '1))
                good_count <= good_count + CNT_ONE;

            if (cnt_clr)
                bad_count <= frame_bad ? CNT_ONE : '0;
            else if (frame_bad && (bad_count != '1))
                bad_count <= bad_count + CNT_ONE;
        end
    end

    assign in_frame = (state != ST_IDLE);

endmodule

// File: tb/tb_xgmii_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_xgmii_frame_checker
//
// Directed bench for xgmii_frame_checker with default parameters. Inputs are
// driven 1 ns after a rising edge and outputs sampled 1 ns after the next one,
// so a pulse caused by a word is visible right after that word is sent.
// -----------------------------------------------------------------------------
module tb_xgmii_frame_checker;

    logic        rx_clk = 1'b0;
    logic        rx_rst;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic        cnt_clr;
    logic        frame_good;
    logic        frame_bad;
    logic [15:0] frame_len;
    logic [15:0] good_count;
    logic [15:0] bad_count;
    logic        in_frame;

    int checks = 0;
    int errors = 0;
    int exp_good = 0;
    int exp_bad  = 0;

    localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
    localparam logic [63:0] START_D = 64'hD5555555555555FB;
    localparam logic [63:0] DATA_D  = 64'hA5A5A5A5A5A5A5A5;

    xgmii_frame_checker dut (
        .rx_clk     (rx_clk),
        .rx_rst     (rx_rst),
        .xgmii_rxd  (xgmii_rxd),
        .xgmii_rxc  (xgmii_rxc),
        .cnt_clr    (cnt_clr),
        .frame_good (frame_good),
        .frame_bad  (frame_bad),
        .frame_len  (frame_len),
        .good_count (good_count),
        .bad_count  (bad_count),
        .in_frame   (in_frame)
    );

    always #5 rx_clk = ~rx_clk;

    // Present one word, then advance to 1 ns past the edge that consumes it.
    task automatic send(input logic [63:0] d, input logic [7:0] c);
        xgmii_rxd = d;
        xgmii_rxc = c;
        @(posedge rx_clk);
        #1;
    endtask

    task automatic send_idle();
        send(IDLE_D, 8'hFF);
    endtask

    task automatic send_start();
        send(START_D, 8'h01);
    endtask

    task automatic send_data(input int n);
        for (int i = 0; i < n; i++) send(DATA_D, 8'h00);
    endtask

    // /T/ on lane k: data before it, /I/ after it.
    task automatic send_term(input int k);
        logic [63:0] d;
        logic [7:0]  c;
        for (int i = 0; i < 8; i++) begin
            if (i < k)       begin d[8*i +: 8] = 8'hA5; c[i] = 1'b0; end
            else if (i == k) begin d[8*i +: 8] = 8'hFD; c[i] = 1'b1; end
            else             begin d[8*i +: 8] = 8'h07; c[i] = 1'b1; end
        end
        send(d, c);
    endtask

    // Checks the pulse that the previous word should have produced.
    task automatic expect_end(input string name, input logic g, input logic b,
                              input logic [15:0] len);
        checks++;
        if (frame_good !== g || frame_bad !== b) begin
            errors++;
            $display("FAIL %s pulse: good=%b bad=%b, required good=%b bad=%b",
                     name, frame_good, frame_bad, g, b);
        end
        checks++;
        if (frame_len !== len) begin
            errors++;
            $display("FAIL %s frame_len: got %0d, required %0d", name, frame_len, len);
        end
        if (g) exp_good++;
        if (b) exp_bad++;
    endtask

    task automatic expect_counts(input string name);
        checks++;
        if (good_count !== 16'(exp_good) || bad_count !== 16'(exp_bad)) begin
            errors++;
            $display("FAIL %s counts: good=%0d bad=%0d, required good=%0d bad=%0d",
                     name, good_count, bad_count, exp_good, exp_bad);
        end
    endtask

    task automatic test_reset();
        rx_rst = 1'b0;
        cnt_clr = 1'b0;
        send_idle();
        send_idle();
        checks++;
        if ({frame_good, frame_bad, in_frame} !== 3'b000 || frame_len !== 16'd0 ||
            good_count !== 16'd0 || bad_count !== 16'd0) begin
            errors++;
            $display("FAIL reset outputs: good=%b bad=%b in=%b len=%0d gc=%0d bc=%0d, required all 0",
                     frame_good, frame_bad, in_frame, frame_len, good_count, bad_count);
        end
        rx_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_idle();
            checks++;
            if ({frame_good, frame_bad, in_frame} !== 3'b000) begin
                errors++;
                $display("FAIL idle word %0d: good=%b bad=%b in=%b, required 0 0 0",
                         i, frame_good, frame_bad, in_frame);
            end
        end
        expect_counts("idle");
    endtask

    // 7 + 9*8 + 1 = 80 bytes.
    task automatic test_good_frame();
        send_start();
        send_data(9);
        checks++;
        if (in_frame !== 1'b1 || frame_good !== 1'b0) begin
            errors++;
            $display("FAIL good mid-frame: in=%b good=%b, required 1 0", in_frame, frame_good);
        end
        send_term(1);
        expect_end("good80", 1'b1, 1'b0, 16'd80);
        send_idle();
        checks++;
        if (frame_good !== 1'b0 || in_frame !== 1'b0) begin
            errors++;
            $display("FAIL good after end: good=%b in=%b, required 0 0", frame_good, in_frame);
        end
        expect_counts("good80");
    endtask

    // /E/ on lane 2 of data word 3: 7 + 16 + 7 + 40 + 1 = 71 bytes, bad.
    task automatic test_error_drop();
        send_start();
        send_data(2);
        send(64'hA5A5A5A5A5FEA5A5, 8'h04);
        checks++;
        if (in_frame !== 1'b1 || dut.state !== 2'd2) begin
            errors++;
            $display("FAIL drop entry: in=%b state=%0d, required 1 2", in_frame, dut.state);
        end
        send_data(5);
        send_term(1);
        expect_end("drop", 1'b0, 1'b1, 16'd71);
        send_idle();
        expect_counts("drop");
    endtask

    task automatic test_lengths();
        // 7 + 64 + 0 = 71 (one short)
        send_start(); send_data(8); send_term(0);
        expect_end("len71", 1'b0, 1'b1, 16'd71);
        // 7 + 1520 + 0 = 1527 (one long)
        send_start(); send_data(190); send_term(0);
        expect_end("len1527", 1'b0, 1'b1, 16'd1527);
        // 7 + 64 + 1 = 72 (minimum)
        send_start(); send_data(8); send_term(1);
        expect_end("len72", 1'b1, 1'b0, 16'd72);
        // 7 + 1512 + 7 = 1526 (maximum)
        send_start(); send_data(189); send_term(7);
        expect_end("len1526", 1'b1, 1'b0, 16'd1526);
        send_idle();
        expect_counts("lengths");
    endtask

    // Restart at 7 + 24 = 31; new frame 7 + 64 + 2 = 73.
    task automatic test_restart();
        send_start();
        send_data(3);
        send_start();
        expect_end("restart_old", 1'b0, 1'b1, 16'd31);
        checks++;
        if (in_frame !== 1'b1) begin
            errors++;
            $display("FAIL restart in_frame: got %b, required 1", in_frame);
        end
        send_data(8);
        send_term(2);
        expect_end("restart_new", 1'b1, 1'b0, 16'd73);
        send_idle();
        expect_counts("restart");
    endtask

    // Lane 4 after /T/ is data, so the 72-byte frame is bad.
    task automatic test_bad_tail();
        send_start();
        send_data(8);
        send(64'h070707A50707FDA5, 8'hEE);
        expect_end("bad_tail", 1'b0, 1'b1, 16'd72);
        send_idle();
        expect_counts("bad_tail");
    endtask

    task automatic test_ignored_start();
        send(64'h070707FB07070707, 8'hFF);
        send_idle();
        checks++;
        if ({frame_good, frame_bad, in_frame} !== 3'b000) begin
            errors++;
            $display("FAIL S on lane 4: good=%b bad=%b in=%b, required 0 0 0",
                     frame_good, frame_bad, in_frame);
        end
        expect_counts("ignored_s");
    endtask

    task automatic test_cnt_clr();
        send_start(); send_data(8); send_term(1);
        expect_end("clr_frame", 1'b1, 1'b0, 16'd72);
        cnt_clr = 1'b1;
        send_idle();
        cnt_clr = 1'b0;
        exp_good = 1;
        exp_bad  = 0;
        expect_counts("cnt_clr");
    endtask

    task automatic test_reset_mid();
        send_start();
        send_data(8);
        rx_rst = 1'b0;
        send_term(1);
        checks++;
        if ({frame_good, frame_bad, in_frame} !== 3'b000 || frame_len !== 16'd0 ||
            good_count !== 16'd0 || bad_count !== 16'd0) begin
            errors++;
            $display("FAIL reset mid-frame: good=%b bad=%b in=%b len=%0d gc=%0d bc=%0d, required all 0",
                     frame_good, frame_bad, in_frame, frame_len, good_count, bad_count);
        end
        rx_rst = 1'b1;
        send_idle();
        send_idle();
        exp_good = 0;
        exp_bad  = 0;
        checks++;
        if (frame_good !== 1'b0 || frame_bad !== 1'b0) begin
            errors++;
            $display("FAIL after reset release: good=%b bad=%b, required 0 0", frame_good, frame_bad);
        end
        expect_counts("reset_mid");
    endtask

    initial begin
        rx_rst    = 1'b0;
        cnt_clr   = 1'b0;
        xgmii_rxd = IDLE_D;
        xgmii_rxc = 8'hFF;
        @(posedge rx_clk);
        #1;
        test_reset();
        test_good_frame();
        test_error_drop();
        test_lengths();
        test_restart();
        test_bad_tail();
        test_ignored_start();
        test_cnt_clr();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
